// File: rtl/img_frame_tx.sv
// img_frame_tx
//   Streams one image frame out through uart_tx so the host can read back the
//   image buffer. The byte stream is one label byte, then IMG_W*IMG_H pixel
//   words of WORD_BYTES bytes each, least-significant byte first. Pixels are
//   scanned with x as the inner loop and y as the outer loop.
//
// Ports
//   sys_clk      system clock, rising edge
//   rst          asynchronous reset, active low
//   frame_start  one-cycle frame request, honoured only while idle
//   label        label byte, sampled when frame_start is accepted
//   busy         high from frame acceptance until the done pulse
//   done         one-cycle pulse after the last byte completes
//   mem_rd_en    image RAM read strobe
//   mem_addr     image RAM read address (y*IMG_W + x)
//   mem_rdata    image RAM read data, valid one cycle after mem_rd_en
//   tx_start     one-cycle start pulse to uart_tx
//   tx_data      byte to uart_tx, held until the byte completes
//   tx_ready     uart_tx idle flag
module img_frame_tx #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 10
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [7:0]              label,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [8*WORD_BYTES-1:0] mem_rdata,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WORD_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEND_LABEL,
        S_FETCH,
        S_RD_WAIT,
        S_LOAD,
        S_SEND_PIX,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                       state;
    logic [XW-1:0]                x;
    logic [YW-1:0]                y;
    logic [BW-1:0]                byte_idx;
    logic [WORD_BYTES-1:0][7:0]   word;
    logic [7:0]                   label_q;
    // Remembers whether the outstanding byte is the label, so the shared
    // handshake states know where to go once the byte completes.
    logic                         in_label;
    logic [ADDR_W-1:0]            pix_addr;

    assign pix_addr = ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tx_start  <= 1'b0;
            mem_rd_en <= 1'b0;
            tx_data   <= '0;
            mem_addr  <= '0;
            x         <= '0;
            y         <= '0;
            byte_idx  <= '0;
            word      <= '0;
            label_q   <= '0;
            in_label  <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            tx_start  <= 1'b0;
            mem_rd_en <= 1'b0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        label_q  <= label;
                        x        <= '0;
                        y        <= '0;
                        byte_idx <= '0;
                        busy     <= 1'b1;
                        state    <= S_SEND_LABEL;
                    end
                end

                S_SEND_LABEL: begin
                    if (tx_ready) begin
                        tx_data  <= label_q;
                        tx_start <= 1'b1;
                        in_label <= 1'b1;
                        state    <= S_WAIT_BUSY;
                    end
                end

                S_FETCH: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= pix_addr;
                    state     <= S_RD_WAIT;
                end

                // The strobe is registered, so it is high during this cycle;
                // the RAM returns data in the following (LOAD) cycle.
                S_RD_WAIT: state <= S_LOAD;

                S_LOAD: begin
                    word     <= mem_rdata;
                    byte_idx <= '0;
                    state    <= S_SEND_PIX;
                end

                S_SEND_PIX: begin
                    if (tx_ready) begin
                        tx_data  <= word[byte_idx];
                        tx_start <= 1'b1;
                        in_label <= 1'b0;
                        state    <= S_WAIT_BUSY;
                    end
                end

                // Wait for uart_tx to acknowledge the start by dropping ready.
                S_WAIT_BUSY: begin
                    if (!tx_ready) state <= S_WAIT_IDLE;
                end

                S_WAIT_IDLE: begin
                    if (tx_ready) state <= in_label ? S_FETCH : S_NEXT;
                end

                S_NEXT: begin
                    if (byte_idx != B_LAST) begin
                        byte_idx <= byte_idx + 1'b1;
                        state    <= S_SEND_PIX;
                    end else if (x != X_LAST) begin
                        x        <= x + 1'b1;
                        byte_idx <= '0;
                        state    <= S_FETCH;
                    end else if (y != Y_LAST) begin
                        x        <= '0;
                        y        <= y + 1'b1;
                        byte_idx <= '0;
                        state    <= S_FETCH;
                    end else begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_frame_tx.sv
module tb_img_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (default parameters) ----------------
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [7:0]  label = 8'h00;
    logic        busy, done, mem_rd_en, tx_start;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    img_frame_tx dut (
        .sys_clk(clk), .rst(rst), .frame_start(frame_start), .label(label),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx_start(tx_start), .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    // ---------------- small DUT ----------------
    logic        s_rst = 1'b1;
    logic        s_start = 1'b0;
    logic [7:0]  s_label = 8'h00;
    logic        s_busy, s_done, s_rd_en, s_tx_start;
    logic [2:0]  s_addr;
    logic [7:0]  s_rdata = 8'h0;
    logic [7:0]  s_tx_data;
    logic        s_tx_ready = 1'b1;

    img_frame_tx #(.IMG_W(2), .IMG_H(3), .WORD_BYTES(1), .ADDR_W(3)) dut_s (
        .sys_clk(clk), .rst(s_rst), .frame_start(s_start), .label(s_label),
        .busy(s_busy), .done(s_done), .mem_rd_en(s_rd_en), .mem_addr(s_addr),
        .mem_rdata(s_rdata), .tx_start(s_tx_start), .tx_data(s_tx_data),
        .tx_ready(s_tx_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- RAM models: garbage unless read the cycle before ----------------
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rdata <= {mem_addr[7:0] + 8'd3, mem_addr[7:0] + 8'd2,
                          mem_addr[7:0] + 8'd1, mem_addr[7:0]};
        else
            mem_rdata <= 32'hDEADBEEF;
        if (s_rd_en) s_rdata <= 8'h40 + {5'b0, s_addr};
        else         s_rdata <= 8'hEE;
    end

    // ---------------- uart_tx models ----------------
    int  busy_len = 10;
    bit  hold = 0;
    int  u_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            tx_ready = 1'b1; u_cnt = 0;
        end else if (tx_start) begin
            tx_ready = 1'b0; u_cnt = busy_len;
        end else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) tx_ready = !hold;
        end else begin
            tx_ready = !hold;
        end
    end

    int s_cnt = 0;
    always @(negedge clk) begin
        if (s_tx_start) begin
            s_tx_ready = 1'b0; s_cnt = 2;
        end else if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) s_tx_ready = 1'b1;
        end
    end

    // ---------------- monitors ----------------
    logic [7:0] cap[$];
    logic [9:0] aq[$];
    int  proto_viol = 0, range_viol = 0, done_cnt = 0, done_bad = 0;
    bit  outst = 0, saw_low = 0, prev_busy = 0;
    logic [7:0] held = 8'h0;
    always begin
        @(posedge clk); #1;
        if (!rst) begin
            outst = 0;
        end else begin
            if (tx_start) begin
                cap.push_back(tx_data);
                if (outst) proto_viol++;
                outst = 1; saw_low = 0; held = tx_data;
            end else if (outst) begin
                if (tx_data !== held) proto_viol++;
                if (!tx_ready) saw_low = 1;
                else if (saw_low) outst = 0;
            end
            if (mem_rd_en) aq.push_back(mem_addr);
            if (mem_addr > 10'd783) range_viol++;
            if (done) begin
                done_cnt++;
                if (busy || !prev_busy) done_bad++;
            end
        end
        prev_busy = busy;
    end

    logic [7:0] s_cap[$];
    logic [2:0] s_aq[$];
    int s_done_cnt = 0, s_done_at = -1;
    always begin
        @(posedge clk); #1;
        if (s_tx_start) s_cap.push_back(s_tx_data);
        if (s_rd_en) s_aq.push_back(s_addr);
        if (s_done) begin s_done_cnt++; s_done_at = s_cap.size(); end
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] exp_byte(input logic [7:0] lbl, input int k);
        logic [7:0] a8, b8;
        if (k == 0) return lbl;
        a8 = 8'((k - 1) / 4);
        b8 = 8'((k - 1) % 4);
        return a8 + b8;
    endfunction

    task automatic pulse_start(input logic [7:0] lbl);
        @(negedge clk); label = lbl; frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic check_stream(input string nm, input logic [7:0] lbl);
        int bad = 0;
        for (int k = 0; k < cap.size(); k++)
            if (cap[k] !== exp_byte(lbl, k)) bad++;
        chk(nm, bad, 0);
    endtask

    task automatic check_addrs(input string nm);
        int bad = 0;
        for (int i = 0; i < aq.size(); i++)
            if (aq[i] !== 10'(i)) bad++;
        chk(nm, bad, 0);
        chk({nm, "_count"}, aq.size(), 784);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt == 0 && t < n) begin @(posedge clk); t++; end
        repeat (5) @(posedge clk);
        chk("done_count", done_cnt, 1);
    endtask

    task automatic wait_bytes(input int nb, input int n);
        int t = 0;
        while (cap.size() < nb && t < n) begin @(posedge clk); t++; end
        chk($sformatf("reach_byte%0d", nb), cap.size() >= nb, 1);
    endtask

    typedef struct { int idx; logic [7:0] exp; } vec_t;
    vec_t vt[10];
    vec_t st[7];

    initial begin
        vt = '{'{0, 8'h07}, '{1, 8'h00}, '{4, 8'h03}, '{5, 8'h01}, '{8, 8'h04},
               '{112, 8'h1E}, '{113, 8'h1C}, '{1025, 8'h00}, '{3133, 8'h0F}, '{3136, 8'h12}};
        st = '{'{0, 8'h9A}, '{1, 8'h40}, '{2, 8'h41}, '{3, 8'h42},
               '{4, 8'h43}, '{5, 8'h44}, '{6, 8'h45}};

        // ---- reset values ----
        #1 rst = 1'b0; s_rst = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1; s_rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---- small parameters ----
        @(negedge clk); s_label = 8'h9A; s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int t = 0; t < 500 && s_done_cnt == 0; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        chk("s_nbytes", s_cap.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("s_byte%0d", st[i].idx),
                (st[i].idx < s_cap.size()) ? 32'(s_cap[st[i].idx]) : 32'h1FF, st[i].exp);
        chk("s_naddr", s_aq.size(), 6);
        for (int i = 0; i < s_aq.size(); i++) chk($sformatf("s_addr%0d", i), s_aq[i], i);
        chk("s_done_count", s_done_cnt, 1);
        chk("s_done_at", s_done_at, 7);
        chk("s_busy_after", s_busy, 0);

        // ---- basic frame ----
        busy_len = 10;
        pulse_start(8'h07);
        wait_done(60000);
        chk("basic_nbytes", cap.size(), 3137);
        foreach (vt[i])
            chk($sformatf("basic_byte%0d", vt[i].idx),
                (vt[i].idx < cap.size()) ? 32'(cap[vt[i].idx]) : 32'h1FF, vt[i].exp);
        check_stream("basic_stream", 8'h07);
        check_addrs("basic_addr");
        chk("basic_busy_after", busy, 0);

        // ---- backpressure then busy request ----
        cap.delete(); aq.delete(); done_cnt = 0;
        busy_len = 1; hold = 1;
        repeat (3) @(negedge clk);
        pulse_start(8'hA5);
        repeat (500) @(negedge clk);
        chk("bp_no_start", cap.size(), 0);
        chk("bp_busy", busy, 1);
        hold = 0;
        wait_bytes(100, 2000);
        pulse_start(8'h55);
        wait_done(30000);
        chk("busyreq_nbytes", cap.size(), 3137);
        chk("busyreq_label", (cap.size() > 0) ? 32'(cap[0]) : 32'h1FF, 8'hA5);
        check_stream("busyreq_stream", 8'hA5);
        check_addrs("busyreq_addr");

        // ---- new frame after done uses new label ----
        cap.delete(); aq.delete(); done_cnt = 0;
        pulse_start(8'h55);
        wait_bytes(5, 200);
        for (int k = 0; k < 5; k++)
            chk($sformatf("second_byte%0d", k),
                (k < cap.size()) ? 32'(cap[k]) : 32'h1FF, exp_byte(8'h55, k));

        // ---- reset mid-frame ----
        wait_bytes(1500, 20000);
        @(posedge clk); #3; rst = 1'b0; #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_start", tx_start, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        begin
            int n0;
            n0 = cap.size();
            repeat (5) @(negedge clk);
            rst = 1'b1;
            repeat (20) @(negedge clk);
            chk("no_tx_after_rst", cap.size(), n0);
        end
        chk("idle_after_rst", busy, 0);
        cap.delete(); aq.delete();
        pulse_start(8'h3C);
        wait_bytes(2, 200);
        chk("restart_label", (cap.size() > 0) ? 32'(cap[0]) : 32'h1FF, 8'h3C);
        chk("restart_addr0", (aq.size() > 0) ? 32'(aq[0]) : 32'hFFF, 0);
        chk("restart_byte1", (cap.size() > 1) ? 32'(cap[1]) : 32'h1FF, 8'h00);

        // ---- global protocol checks ----
        chk("protocol_violations", proto_viol, 0);
        chk("addr_range_violations", range_viol, 0);
        chk("done_busy_alignment", done_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_frame_tx.md
Name: img_frame_tx

Overview:
- Streams one image frame out through uart_tx, so the host can read back the image buffer.
- Byte order matches what the image receiver accepts: 1 label byte, then IMG_W*IMG_H pixel words of WORD_BYTES bytes each, least-significant byte first.
- Pixel scan order: x inner (0..IMG_W-1), y outer.
- Reads pixel words from a synchronous image RAM and drives the uart_tx start/data/ready handshake. Sits beside uart_rx/uart_tx in the top level.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame.
- WORD_BYTES, 4, bytes per pixel word; word width is 8*WORD_BYTES.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle request to send a frame; honoured only in IDLE.
- label  in  8  label byte; sampled when frame_start is accepted.
- busy  out  1  high from frame_start acceptance until the done pulse.
- done  out  1  one-cycle pulse after the last byte completes.
- mem_rd_en  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address, equal to y*IMG_W+x.
- mem_rdata  in  8*WORD_BYTES  RAM read data, valid exactly 1 cycle after mem_rd_en.
- tx_start  out  1  one-cycle pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; held stable from tx_start until the byte completes.
- tx_ready  in  1  uart_tx idle flag.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - busy, done, tx_start, mem_rd_en = 0; tx_data = 0; mem_addr = 0.
  - x, y, byte_idx = 0; word and label registers = 0.
- IDLE:
  - On frame_start: latch label, clear x/y/byte_idx, set busy, go to SEND_LABEL.
  - frame_start while busy is ignored; no queuing.
- Sending a byte (shared by label and pixel bytes):
  - Wait in the issuing state until tx_ready=1.
  - Drive tx_data with the byte and pulse tx_start for exactly 1 cycle.
  - Go to WAIT_BUSY: wait for tx_ready=0.
  - Go to WAIT_IDLE: wait for tx_ready=1; the byte is then complete.
  - Only one byte may be outstanding at a time.
- SEND_LABEL: send the latched label byte, then go to FETCH.
- FETCH: pulse mem_rd_en 1 cycle with mem_addr = y*IMG_W+x; go to LOAD.
- LOAD: capture mem_rdata into the word register; byte_idx=0; go to SEND_PIX.
- SEND_PIX:
  - Send word[8*byte_idx +: 8] via the byte handshake.
  - After WAIT_IDLE, go to NEXT.
- NEXT:
  - byte_idx < WORD_BYTES-1: byte_idx+1, go to SEND_PIX.
  - Else if x < IMG_W-1: x+1, byte_idx=0, go to FETCH.
  - Else if y < IMG_H-1: x=0, y+1, go to FETCH.
  - Else go to DONE.
- DONE: pulse done 1 cycle, clear busy, return to IDLE.
- Counters:
  - x, y are clog2-sized; byte_idx is clog2(WORD_BYTES) wide.
  - Address is computed in ADDR_W bits with no overflow.
  - x, y, byte_idx never wrap; NEXT terminates the frame.
- Frame totals:
  - 1 + IMG_W*IMG_H*WORD_BYTES tx_start pulses; defaults give 3137.
  - IMG_W*IMG_H mem_rd_en pulses; defaults give 784.
- tx_ready stuck high after tx_start: the block stays in WAIT_BUSY forever. No timeout; uart_tx guarantees ready drops within 1 cycle.
- Reset mid-frame:
  - Immediate return to IDLE with all outputs at reset values.
  - No further tx_start is issued.
  - A byte already in uart_tx is uart_tx's concern.
- Frame size: 0 <= mem_addr <= IMG_W*IMG_H-1 at all times.

Test Plan:
- Basic frame: label=8'h07; RAM[a] = {a[7:0]+3, a[7:0]+2, a[7:0]+1, a[7:0]}; uart_tx model with ready low for 10 cycles per byte.
  -> 3137 bytes, in order 07, 00,01,02,03, 01,02,03,04, ...
  -> last address 783 (783 mod 256 = 15) ends with 0F,10,11,12
  -> done pulses once; busy falls the same cycle.
- Address order: RAM[a]=a; capture mem_addr on each mem_rd_en.
  -> sequence 0,1,...,27,28,...,783.
  -> mem_rdata sampled exactly 1 cycle after the strobe.
- Backpressure: hold tx_ready=0 for 500 cycles before the label.
  -> no tx_start until tx_ready rises.
  -> tx_data stable through every WAIT_BUSY/WAIT_IDLE.
  -> never two tx_start pulses without an intervening tx_ready low-then-high.
- Busy request: frame_start again at byte 100, label=8'h55.
  -> ignored; the frame still carries the original label.
  -> a frame_start after done starts a new frame with label 8'h55.
- Reset mid-frame: assert rst=0 at byte 1500, asynchronously between clock edges.
  -> busy, tx_start, mem_rd_en go to 0 without waiting for a clock edge.
  -> after release, a new frame_start restarts at label then address 0.
- Small parameters: IMG_W=2, IMG_H=3, WORD_BYTES=1, ADDR_W=3.
  -> 7 bytes; addresses 0..5; done pulses after byte 7.
